// File: rtl/step_cmd_sequencer.sv
// Move-command FIFO and sequencer feeding the step pulse generator: direction setup,
// run/finish handshake, inter-move gap, abort with remainder capture, start timeout.
module step_cmd_sequencer #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DIR_SETUP   = 4,
  parameter int unsigned GAP         = 2,
  parameter int unsigned ARM_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_reduction,
  input  logic [30:0]              cmd_count,
  input  logic                     cmd_dir,
  input  logic                     abort,
  output logic                     gen_run,
  output logic [31:0]              gen_reduction,
  output logic [30:0]              gen_count,
  input  logic                     gen_finish,
  input  logic [30:0]              gen_remainder,
  output logic                     dir,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     cmd_reject,
  output logic                     fault,
  output logic [15:0]              moves_done,
  output logic [30:0]              aborted_steps
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ARM, S_RUN, S_HOLD, S_DRAIN} state_t;

  state_t        state;
  logic [31:0]   timer;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [63:0]   head;
  logic          empty;
  logic          push;
  logic          pop;
  logic          abort_take;
  logic          timeout;
  logic          flush;

  assign head       = mem[rd_ptr];
  assign empty      = (fifo_level == '0);
  assign cmd_ready  = (fifo_level < FULL) && !abort && (state != S_DRAIN);
  assign push       = cmd_valid && cmd_ready;
  // Abort is ignored while already draining so a held abort cannot restart DRAIN
  // and block the remainder capture.
  assign abort_take = abort && (state != S_DRAIN) && !((state == S_IDLE) && empty);
  assign timeout    = (state == S_ARM) && gen_finish && (timer == ARM_TIMEOUT - 1);
  assign flush      = abort_take || timeout;
  assign pop        = (state == S_IDLE) && !empty && !abort_take;
  assign busy       = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_dir, cmd_count, cmd_reduction};
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      timer         <= '0;
      gen_run       <= 1'b0;
      gen_reduction <= '0;
      gen_count     <= '0;
      dir           <= 1'b0;
      cmd_reject    <= 1'b0;
      fault         <= 1'b0;
      moves_done    <= '0;
      aborted_steps <= '0;
    end else begin
      cmd_reject <= 1'b0;
      if (abort_take) begin
        state   <= S_DRAIN;
        gen_run <= 1'b0;
        timer   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!empty) begin
              if (head[62:32] == '0 || head[31:0] == '0) begin
                cmd_reject <= 1'b1;
              end else begin
                gen_reduction <= head[31:0];
                gen_count     <= head[62:32];
                dir           <= head[63];
                timer         <= '0;
                state         <= S_SETUP;
              end
            end
          end
          S_SETUP: begin
            if (timer == DIR_SETUP - 1) begin
              gen_run <= 1'b1;
              timer   <= '0;
              state   <= S_ARM;
            end else begin
              timer <= timer + 32'd1;
            end
          end
          S_ARM: begin
            if (!gen_finish) begin
              state <= S_RUN;
            end else if (timeout) begin
              fault   <= 1'b1;
              gen_run <= 1'b0;
              state   <= S_IDLE;
            end else begin
              timer <= timer + 32'd1;
            end
          end
          S_RUN: begin
            if (gen_finish) begin
              gen_run    <= 1'b0;
              moves_done <= moves_done + 16'd1;
              timer      <= '0;
              state      <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (timer == GAP - 1) state <= S_IDLE;
            else                  timer <= timer + 32'd1;
          end
          S_DRAIN: begin
            if (timer == 32'd1) begin
              aborted_steps <= gen_remainder;
              state         <= S_IDLE;
            end else begin
              timer <= timer + 32'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
